// File: rtl/perf_window_ctrl_pkg.sv
// Shared widths and state encodings for the performance measurement window controller.
package perf_window_ctrl_pkg;

    localparam int unsigned CYCLE_CNT_W = 32;
    localparam int unsigned PERF_CNT_W  = CYCLE_CNT_W;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StCount  = 3'd2,
        StReport = 3'd3,
        StDone   = 3'd4
    } pw_state_e;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on each rising edge of d_i; the history register updates every cycle.
module rise_detect (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign pulse_o = d_i & ~prev_q;

endmodule

// File: rtl/perf_window_ctrl.sv
// Measurement-window controller: arm, open on trigger, count cycles or retire edges,
// close on stop or saturation, then hand the final count over a valid/ready handshake.
module perf_window_ctrl
    import perf_window_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             arm_i,
    input  logic             mode_i,
    input  logic             trigger_i,
    input  logic             stop_i,
    input  logic             retire_i,
    input  logic             report_ready_i,
    output logic             report_valid_o,
    output logic [CNT_W-1:0] report_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [2:0]       state_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    pw_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, data_q, data_d, count_inc;
    logic             ov_q, ov_d, mode_q, mode_d, valid_q, valid_d, busy_q, busy_d;
    logic             retire_rise;

    rise_detect u_retire_rise (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .d_i     (retire_i),
        .pulse_o (retire_rise)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // Saturating increment; in mode 1 only a retire rising edge counts.
        count_inc = count_q;
        if ((!mode_q || retire_rise) && (count_q != CntMax)) begin
            count_inc = count_q + CntOne;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle:   if (arm_i) state_d = StArmed;
            StArmed: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end else if (trigger_i) begin
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end else if (stop_i || (count_inc == CntMax)) begin
                    state_d = StReport;
                end
            end
            StReport: if (report_ready_i) state_d = StDone;
            StDone:   if (!arm_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        ov_d    = ov_q;
        mode_d  = mode_q;
        data_d  = data_q;
        unique case (state_q)
            StArmed: begin
                if (arm_i && trigger_i) begin
                    count_d = '0;
                    ov_d    = 1'b0;
                    mode_d  = mode_i;
                end
            end
            StCount: begin
                if (arm_i) begin
                    count_d = count_inc;
                    if (state_d == StReport) begin
                        data_d = count_inc;
                        ov_d   = !stop_i;
                    end
                end
            end
            default: ;
        endcase
        valid_d = (state_d == StReport);
        busy_d  = (state_d == StCount) || (state_d == StReport);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
            data_q  <= '0;
            ov_q    <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            ov_q    <= ov_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign report_valid_o = valid_q;
    assign report_data_o  = data_q;
    assign count_o        = count_q;
    assign overflow_o     = ov_q;
    assign busy_o         = busy_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Bench for perf_window_ctrl: 32-bit and 4-bit instances share stimulus and a behavioural model.
module tb_perf_window_ctrl;

    logic clk = 1'b0;
    logic rstn, arm, mode, trig, stop, retire, ready;
    always #5 clk = ~clk;

    logic [31:0] a_data, a_count;
    logic        a_valid, a_ov, a_busy;
    logic [2:0]  a_state;
    logic [3:0]  b_data, b_count;
    logic        b_valid, b_ov, b_busy;
    logic [2:0]  b_state;

    perf_window_ctrl u_dut32 (
        .clk_i(clk), .rstn_i(rstn), .arm_i(arm), .mode_i(mode), .trigger_i(trig),
        .stop_i(stop), .retire_i(retire), .report_ready_i(ready),
        .report_valid_o(a_valid), .report_data_o(a_data), .count_o(a_count),
        .overflow_o(a_ov), .busy_o(a_busy), .state_o(a_state)
    );

    perf_window_ctrl #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rstn_i(rstn), .arm_i(arm), .mode_i(mode), .trigger_i(trig),
        .stop_i(stop), .retire_i(retire), .report_ready_i(ready),
        .report_valid_o(b_valid), .report_data_o(b_data), .count_o(b_count),
        .overflow_o(b_ov), .busy_o(b_busy), .state_o(b_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one entry per instance, states numbered as on state_o.
    int          m_st   [2];
    logic [63:0] m_cnt  [2];
    logic [63:0] m_data [2];
    logic [63:0] m_max  [2] = '{64'hFFFF_FFFF, 64'hF};
    bit          m_ov   [2];
    bit          m_mode [2];
    bit          m_prev [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit rose;
            rose = retire && !m_prev[i];
            if (!rstn) begin
                m_st[i] = 0; m_cnt[i] = 0; m_data[i] = 0;
                m_ov[i] = 0; m_mode[i] = 0; m_prev[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (arm) m_st[i] = 1;
                    1: begin
                        if (!arm) m_st[i] = 0;
                        else if (trig) begin
                            m_cnt[i] = 0; m_ov[i] = 0; m_mode[i] = mode; m_st[i] = 2;
                        end
                    end
                    2: begin
                        if (!arm) m_st[i] = 0;
                        else begin
                            if (!m_mode[i] || rose)
                                m_cnt[i] = (m_cnt[i] < m_max[i]) ? m_cnt[i] + 1 : m_max[i];
                            if (stop) begin
                                m_data[i] = m_cnt[i]; m_st[i] = 3;
                            end else if (m_cnt[i] == m_max[i]) begin
                                m_data[i] = m_cnt[i]; m_ov[i] = 1; m_st[i] = 3;
                            end
                        end
                    end
                    3: if (ready) m_st[i] = 4;
                    4: if (!arm) m_st[i] = 0;
                    default: m_st[i] = 0;
                endcase
                m_prev[i] = retire;
            end
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("m32_state", a_state, m_st[0]);
            check("m32_count", a_count, m_cnt[0]);
            check("m32_valid", a_valid, m_st[0] == 3);
            check("m32_data",  a_data,  m_data[0]);
            check("m32_ovf",   a_ov,    m_ov[0]);
            check("m32_busy",  a_busy,  m_st[0] == 2 || m_st[0] == 3);
            check("m4_state",  b_state, m_st[1]);
            check("m4_count",  b_count, m_cnt[1]);
            check("m4_valid",  b_valid, m_st[1] == 3);
            check("m4_data",   b_data,  m_data[1]);
            check("m4_ovf",    b_ov,    m_ov[1]);
            check("m4_busy",   b_busy,  m_st[1] == 2 || m_st[1] == 3);
        end
    end

    bit pat [8] = '{1, 1, 0, 1, 0, 1, 1, 1};
    int waited;

    initial begin
        rstn = 0; arm = 1; mode = 1; trig = 1; stop = 1; retire = 1; ready = 1;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_state", a_state, 0);
        check("rst_count", a_count, 0);
        check("rst_valid", a_valid, 0);
        check("rst_data",  a_data,  0);
        check("rst_ovf",   a_ov,    0);
        check("rst_busy",  a_busy,  0);
        check("rst_state4", b_state, 0);

        rstn = 1; mode = 0; trig = 0; stop = 0; retire = 0;
        @(negedge clk);
        check("armed", a_state, 1);

        // Mode 0: stop ten cycles after trigger.
        trig = 1; @(negedge clk); trig = 0;
        check("m0_open_state", a_state, 2);
        check("m0_open_count", a_count, 0);
        repeat (9) @(negedge clk);
        stop = 1; @(negedge clk); stop = 0;
        check("m0_valid", a_valid, 1);
        check("m0_data",  a_data,  10);
        check("m0_state", a_state, 3);
        @(negedge clk);
        check("m0_done", a_state, 4);
        arm = 0; @(negedge clk);
        check("m0_idle", a_state, 0);

        // Mode 1: retire pattern, then again with retire already high at trigger.
        for (int v = 0; v < 2; v++) begin
            arm = 1; mode = 1; @(negedge clk);
            retire = (v == 1); trig = 1; @(negedge clk); trig = 0;
            for (int k = 0; k < 8; k++) begin
                retire = pat[k]; stop = (k == 7); @(negedge clk);
            end
            stop = 0; retire = 0;
            check("m1_valid", a_valid, 1);
            check("m1_data",  a_data, (v == 0) ? 3 : 2);
            arm = 0; repeat (2) @(negedge clk);
            check("m1_idle", a_state, 0);
        end

        // Back-pressure in REPORT while arm drops.
        arm = 1; mode = 0; ready = 0; @(negedge clk);
        trig = 1; @(negedge clk); trig = 0;
        repeat (3) @(negedge clk);
        stop = 1; @(negedge clk); stop = 0; arm = 0;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", a_valid, 1);
            check("bp_data",  a_data,  4);
            @(negedge clk);
        end
        ready = 1; @(negedge clk);
        check("bp_done", a_state, 4);
        @(negedge clk);
        check("bp_idle", a_state, 0);

        // Abort mid-window.
        arm = 1; @(negedge clk);
        trig = 1; @(negedge clk); trig = 0;
        repeat (3) @(negedge clk);
        arm = 0; @(negedge clk);
        check("abort_state", a_state, 0);
        check("abort_valid", a_valid, 0);

        // Trigger and stop together in ARMED: window opens and stays open.
        arm = 1; @(negedge clk);
        trig = 1; stop = 1; @(negedge clk); trig = 0; stop = 0;
        check("ts_state", a_state, 2);
        @(negedge clk);
        check("ts_still_open", a_state, 2);
        check("ts_count", a_count, 1);
        stop = 1; @(negedge clk); stop = 0;
        @(negedge clk);
        arm = 0; @(negedge clk);

        // Saturation on the 4-bit instance.
        arm = 1; @(negedge clk);
        trig = 1; @(negedge clk); trig = 0;
        waited = 0;
        while (!b_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("sat_cycles", waited, 15);
        check("sat_data",   b_data, 15);
        check("sat_ovf",    b_ov, 1);
        check("sat_count",  b_count, 15);
        check("sat_ovf32",  a_ov, 0);
        stop = 1; @(negedge clk); stop = 0;
        check("sat32_data", a_data, 16);
        check("sat_hold_ovf", b_ov, 1);
        check("sat_hold_state", b_state, 4);
        arm = 0; repeat (2) @(negedge clk);

        // Reset mid-window discards the count.
        arm = 1; @(negedge clk);
        trig = 1; @(negedge clk); trig = 0;
        repeat (2) @(negedge clk);
        rstn = 0; @(negedge clk);
        check("mrst_state", a_state, 0);
        check("mrst_count", a_count, 0);
        check("mrst_valid", a_valid, 0);
        rstn = 1; arm = 0; @(negedge clk);
        check("mrst_idle", a_state, 0);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
